// File: rtl/int_flag_sequencer_if.sv
// -----------------------------------------------------------------------------
// int_flag_sequencer_if
//   Request/acknowledge handshake between the interrupt/trap sequencer and the
//   microcode sequencer.
//
//   int_req     sequencer -> microcode  interrupt/trap request
//   int_vector  sequencer -> microcode  vector, valid while int_req=1
//   int_ack     microcode -> sequencer  request accepted, FLAGS/CS/IP pushed
//
//   master: the interrupt/trap sequencer (int_flag_sequencer)
//   slave : the microcode sequencer
// -----------------------------------------------------------------------------
interface int_flag_sequencer_if;
  logic       int_req;
  logic [7:0] int_vector;
  logic       int_ack;

  modport master (output int_req, output int_vector, input int_ack);
  modport slave  (input int_req, input int_vector, output int_ack);
endinterface

// File: rtl/int_flag_sequencer.sv
// -----------------------------------------------------------------------------
// int_flag_sequencer
//   At each instruction boundary, picks NMI, maskable interrupt or single-step
//   trap (in that priority), hands the vector to microcode over a req/ack
//   handshake, then spends one cycle clearing IF and TF through the flags
//   register update port. The clear is merged into the microcode/ALU flag
//   write path; TF/IF writes from the sequencer win, all others pass through.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset
//   flags             current flags register (TF = bit 8, IF = bit 9)
//   instr_done        one-cycle pulse at an instruction boundary
//   inhibit           pulse that shadows the next boundary (STI, MOV/POP SS)
//   nmi               synchronised NMI pin, rising-edge sensitive
//   intr              maskable interrupt request, level
//   intr_vector       vector supplied with intr
//   ext_update_flags  flag-update mask from microcode/ALU
//   ext_flags_in      flag values from microcode/ALU
//   bus               req/ack handshake to microcode (master side)
//   update_flags      merged update mask to the flags register
//   flags_in          merged flag values to the flags register
//
// Update-mask bit order (9 writable flags):
//   0 CF, 1 PF, 2 AF, 3 ZF, 4 SF, 5 TF, 6 IF, 7 DF, 8 OF
// -----------------------------------------------------------------------------
module int_flag_sequencer #(
  parameter logic [7:0] NMI_VECTOR  = 8'd2,
  parameter logic [7:0] TRAP_VECTOR = 8'd1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 flags,
  input  logic                        instr_done,
  input  logic                        inhibit,
  input  logic                        nmi,
  input  logic                        intr,
  input  logic [7:0]                  intr_vector,
  input  logic [8:0]                  ext_update_flags,
  input  logic [15:0]                 ext_flags_in,
  int_flag_sequencer_if.master        bus,
  output logic [8:0]                  update_flags,
  output logic [15:0]                 flags_in
);

  localparam int UF_TF = 5;  // TF bit in the update mask
  localparam int UF_IF = 6;  // IF bit in the update mask
  localparam int FL_TF = 8;  // TF bit in the flags word
  localparam int FL_IF = 9;  // IF bit in the flags word

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t     state_q;
  logic       int_req_q;
  logic [7:0] int_vector_q;
  logic       req_is_nmi_q;
  logic       nmi_prev_q;
  logic       nmi_pending_q;
  logic       shadow_q;
  logic       tf_armed_q;

  logic       nmi_pending_d;
  logic       shadow_d;
  logic       nmi_edge;
  logic       nmi_acked;

  // Only TF and IF of the flags word steer decisions.
  logic       unused_flags;
  assign unused_flags = ^{flags[15:10], flags[7:0]};

  assign nmi_edge  = nmi & ~nmi_prev_q;
  assign nmi_acked = (state_q == REQ) & bus.int_ack & req_is_nmi_q;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nmi_pending_d = nmi_pending_q;
    if (nmi_acked) nmi_pending_d = 1'b0;
    // A new edge in the acknowledge cycle must not be lost: set wins.
    if (nmi_edge)  nmi_pending_d = 1'b1;

    shadow_d = shadow_q;
    // instr_done outside IDLE is ignored and leaves the shadow alone.
    if (instr_done && state_q == IDLE) shadow_d = 1'b0;
    // Inhibit in the same cycle as a boundary shadows the following one.
    if (inhibit) shadow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      int_req_q     <= 1'b0;
      int_vector_q  <= 8'h00;
      req_is_nmi_q  <= 1'b0;
      // Treat NMI as already high so a level held across reset is not taken.
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      shadow_q      <= 1'b0;
      tf_armed_q    <= 1'b0;
    end else begin
      nmi_prev_q    <= nmi;
      nmi_pending_q <= nmi_pending_d;
      shadow_q      <= shadow_d;

      unique case (state_q)
        IDLE: begin
          if (instr_done) begin
            // Arming on the boundary delays a freshly set TF by one
            // instruction, so POPF itself does not trap.
            tf_armed_q <= flags[FL_TF];
            if (!shadow_q) begin
              if (nmi_pending_q) begin
                int_req_q    <= 1'b1;
                int_vector_q <= NMI_VECTOR;
                req_is_nmi_q <= 1'b1;
                state_q      <= REQ;
              end else if (intr && flags[FL_IF]) begin
                int_req_q    <= 1'b1;
                int_vector_q <= intr_vector;
                req_is_nmi_q <= 1'b0;
                state_q      <= REQ;
              end else if (tf_armed_q) begin
                int_req_q    <= 1'b1;
                int_vector_q <= TRAP_VECTOR;
                req_is_nmi_q <= 1'b0;
                state_q      <= REQ;
              end
            end
          end
        end
        REQ: begin
          // Request stays up even if intr drops; only the ack retires it.
          if (bus.int_ack) begin
            int_req_q <= 1'b0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          // The handler's first instruction must not single-step trap.
          tf_armed_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vector = int_vector_q;

  // Merge the IF/TF clear into the external flag write path.
  always_comb begin
    update_flags = ext_update_flags;
    flags_in     = ext_flags_in;
    if (state_q == CLEAR) begin
      update_flags[UF_TF] = 1'b1;
      update_flags[UF_IF] = 1'b1;
      flags_in[FL_TF]     = 1'b0;
      flags_in[FL_IF]     = 1'b0;
    end
  end

endmodule

// File: tb/tb_int_flag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_int_flag_sequencer
//   Directed, self-checking bench for int_flag_sequencer. Inputs change 1 ns
//   after a rising edge and outputs are sampled at that same point, well away
//   from the next active edge.
// -----------------------------------------------------------------------------
module tb_int_flag_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] flags;
  logic        instr_done;
  logic        inhibit;
  logic        nmi;
  logic        intr;
  logic [7:0]  intr_vector;
  logic [8:0]  ext_update_flags;
  logic [15:0] ext_flags_in;
  logic [8:0]  update_flags;
  logic [15:0] flags_in;

  int checks = 0;
  int errors = 0;

  int_flag_sequencer_if bus ();

  int_flag_sequencer #(
    .NMI_VECTOR  (8'd2),
    .TRAP_VECTOR (8'd1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flags            (flags),
    .instr_done       (instr_done),
    .inhibit          (inhibit),
    .nmi              (nmi),
    .intr             (intr),
    .intr_vector      (intr_vector),
    .ext_update_flags (ext_update_flags),
    .ext_flags_in     (ext_flags_in),
    .bus              (bus.master),
    .update_flags     (update_flags),
    .flags_in         (flags_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle instruction boundary pulse.
  task automatic boundary();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
  endtask

  // One-cycle acknowledge from microcode.
  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    flags            = 16'h0000;
    instr_done       = 1'b0;
    inhibit          = 1'b0;
    nmi              = 1'b1;
    intr             = 1'b0;
    intr_vector      = 8'h00;
    ext_update_flags = 9'h000;
    ext_flags_in     = 16'h0000;
    bus.int_ack      = 1'b0;

    // ---- Reset with NMI held high ----
    tick();
    tick();
    check("reset_int_req", {15'd0, bus.int_req}, 16'h0000);
    check("reset_int_vector", {8'd0, bus.int_vector}, 16'h0000);
    check("reset_update_flags", {7'd0, update_flags}, 16'h0000);
    reset = 1'b0;
    tick();

    // NMI level held across reset is not an edge.
    boundary();
    check("nmi_held_no_req", {15'd0, bus.int_req}, 16'h0000);

    // Fresh rising edge, then a boundary takes it.
    nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    boundary();
    check("nmi_req", {15'd0, bus.int_req}, 16'h0001);
    check("nmi_vector", {8'd0, bus.int_vector}, 16'h0002);
    ext_flags_in = 16'h0300;
    tick();
    check("nmi_req_held", {15'd0, bus.int_req}, 16'h0001);
    ack();
    check("nmi_clear_req_low", {15'd0, bus.int_req}, 16'h0000);
    check("nmi_clear_mask", {7'd0, update_flags}, 16'h0060);
    check("nmi_clear_values", flags_in, 16'h0000);
    tick();
    check("nmi_idle_mask", {7'd0, update_flags}, 16'h0000);
    check("nmi_idle_values", flags_in, 16'h0300);
    ext_flags_in = 16'h0000;
    // Pending NMI retired by the ack; no new edge, so nothing is taken.
    boundary();
    check("nmi_retired", {15'd0, bus.int_req}, 16'h0000);

    // ---- Maskable interrupt ----
    flags       = 16'h0200;
    intr        = 1'b1;
    intr_vector = 8'h21;
    boundary();
    check("intr_req", {15'd0, bus.int_req}, 16'h0001);
    check("intr_vector", {8'd0, bus.int_vector}, 16'h0021);
    // Request and vector hold after intr drops; boundaries in REQ are ignored.
    intr        = 1'b0;
    intr_vector = 8'h55;
    boundary();
    tick();
    check("intr_req_held", {15'd0, bus.int_req}, 16'h0001);
    check("intr_vector_held", {8'd0, bus.int_vector}, 16'h0021);
    ext_flags_in = 16'h0300;
    ack();
    check("intr_clear_mask", {7'd0, update_flags}, 16'h0060);
    check("intr_clear_values", flags_in, 16'h0000);
    tick();
    check("intr_idle_mask", {7'd0, update_flags}, 16'h0000);
    ext_flags_in = 16'h0000;

    // ---- Priority: NMI over intr over trap ----
    flags = 16'h0300;
    boundary();  // arms TF, no source yet
    check("arm_tf_no_req", {15'd0, bus.int_req}, 16'h0000);
    nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    intr        = 1'b1;
    intr_vector = 8'h21;
    boundary();
    check("prio_vector", {8'd0, bus.int_vector}, 16'h0002);
    ack();
    tick();
    // Handler cleared IF/TF; intr still high but masked, trap disarmed.
    flags = 16'h0000;
    boundary();
    check("masked_no_req", {15'd0, bus.int_req}, 16'h0000);

    // ---- Interrupt shadow ----
    intr  = 1'b0;
    flags = 16'h0200;
    inhibit = 1'b1;
    boundary();  // inhibit coincident with boundary: shadows the next one
    inhibit = 1'b0;
    check("inhibit_same_cycle", {15'd0, bus.int_req}, 16'h0000);
    intr = 1'b1;
    boundary();
    check("shadowed_boundary", {15'd0, bus.int_req}, 16'h0000);
    boundary();
    check("after_shadow_req", {15'd0, bus.int_req}, 16'h0001);
    check("after_shadow_vector", {8'd0, bus.int_vector}, 16'h0021);
    ack();
    tick();
    intr = 1'b0;
    inhibit = 1'b1;
    tick();
    inhibit = 1'b0;
    intr = 1'b1;
    boundary();
    check("inhibit_pulse_shadow", {15'd0, bus.int_req}, 16'h0000);
    boundary();
    check("inhibit_pulse_req", {15'd0, bus.int_req}, 16'h0001);
    ack();
    tick();
    intr = 1'b0;

    // ---- Single-step trap after POPF ----
    flags = 16'h0100;
    boundary();
    check("popf_no_trap", {15'd0, bus.int_req}, 16'h0000);
    boundary();
    check("trap_req", {15'd0, bus.int_req}, 16'h0001);
    check("trap_vector", {8'd0, bus.int_vector}, 16'h0001);
    ext_update_flags = 9'h001;
    ext_flags_in     = 16'h0201;
    ack();
    check("merge_mask", {7'd0, update_flags}, 16'h0061);
    check("merge_values", flags_in, 16'h0001);
    tick();
    check("merge_idle_mask", {7'd0, update_flags}, 16'h0001);
    check("merge_idle_values", flags_in, 16'h0201);
    ext_update_flags = 9'h000;
    ext_flags_in     = 16'h0000;
    flags            = 16'h0000;

    // ---- Reset mid-handshake ----
    flags       = 16'h0200;
    intr        = 1'b1;
    intr_vector = 8'h21;
    boundary();
    check("pre_reset_req", {15'd0, bus.int_req}, 16'h0001);
    reset       = 1'b1;
    bus.int_ack = 1'b1;
    tick();
    reset       = 1'b0;
    bus.int_ack = 1'b0;
    intr        = 1'b0;
    check("reset_req_dropped", {15'd0, bus.int_req}, 16'h0000);
    check("reset_vector_cleared", {8'd0, bus.int_vector}, 16'h0000);
    check("reset_no_clear", {7'd0, update_flags}, 16'h0000);
    tick();
    check("reset_no_clear_late", {7'd0, update_flags}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
